// File: rtl/e_mdu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// Carries the issue strobe with its operands, and returns busy plus the HI/LO registers.
interface e_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, A, B, input busy, HI, LO);
    modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a busy flag for hazard stalling.
// Results are computed combinationally from latched operands and committed when the cycle count expires.
module e_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic   clk,
    input logic   reset,
    e_mdu_if.slave bus
);
    // Handshake: start is sampled every rising edge and accepted only while busy=0;
    // busy rises the cycle after a mult/div issue and stays high exactly MUL/DIV_CYCLES cycles.
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic             is_mul, is_div, issue, done, write_ok;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               signed_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, num, den, q_raw, r_raw, q_res, r_res;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (bus.start && (is_mul || is_div)) begin
                issue      = 1'b1;
                state_next = RUN;
            end
            RUN: if (cnt == CW'(1)) begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Sign-extended operands give the signed product in the low 2*WIDTH bits.
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide runs on magnitudes; most-negative / -1 falls out as most-negative, remainder 0.
    assign signed_div = (op_q == OP_DIV);
    assign a_neg = signed_div && a_q[WIDTH-1];
    assign b_neg = signed_div && b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    assign num   = a_mag;
    assign den   = (b_mag == '0) ? WIDTH'(1) : b_mag;
    assign q_raw = num / den;
    assign r_raw = num % den;
    assign q_res = (a_neg ^ b_neg) ? -q_raw : q_raw;
    assign r_res = a_neg ? -r_raw : r_raw;

    always_comb begin
        res_hi   = hi_q;
        res_lo   = lo_q;
        write_ok = 1'b1;
        case (op_q)
            OP_MULT:  begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
            OP_MULTU: begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
            OP_DIV, OP_DIVU: begin
                res_hi   = r_res;
                res_lo   = q_res;
                write_ok = (b_q != '0);
            end
            default: write_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (issue) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.op;
                cnt  <= is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end
            if (state == IDLE && bus.start && bus.op == OP_MTHI) hi_q <= bus.A;
            if (state == IDLE && bus.start && bus.op == OP_MTLO) lo_q <= bus.A;
            if (done && write_ok) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Parametrised multiply/divide unit in the E stage, alongside the combinational E-stage ALU.
- Executes signed/unsigned multiply and divide over a fixed, configurable number of cycles into internal HI/LO registers.
- Also supports direct writes to HI/LO.
- Exposes a busy flag so the hazard unit can stall dependent HI/LO instructions.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MUL_CYCLES, 5, busy cycles for a multiply (>=1).
- DIV_CYCLES, 10, busy cycles for a divide (>=1).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  operation issue strobe, sampled each rising edge.
- op  input  4  operation select: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, others none.
- A  input  WIDTH  operand A (dividend, multiplicand, or mthi/mtlo source).
- B  input  WIDTH  operand B (divisor, multiplier).
- busy  output  1  high while a multiply/divide is in progress.
- HI  output  WIDTH  HI register: product upper half, or remainder.
- LO  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset (clk edge with reset=1):
  - busy=0, HI=0, LO=0.
  - Internal counter and latched operands cleared.
  - Any in-flight operation is abandoned; no HI/LO update from it.
  - reset has priority over start.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- IDLE, start=1, op in {mult, multu, div, divu}:
  - A, B and op are latched on that edge.
  - Counter is loaded with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - busy=1 from the following cycle.
- IDLE, start=1, op=mthi/mtlo:
  - HI (resp. LO) <= A on that edge, visible next cycle.
  - Remains IDLE; busy stays 0.
- IDLE, start=1, op none/undefined: no state change.
- start=0: op/A/B are ignored.
- RUN:
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0, HI/LO are written with the result and the unit returns to IDLE.
  - Result is visible, and busy=0, in the same following cycle.
- Timing: issue at edge t gives busy=1 for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES); new HI/LO is visible from the cycle after busy falls.
- Any start (including mthi/mtlo) while busy=1 is ignored. HI/LO and in-flight operands are unaffected. The pipeline must stall rather than issue.
- HI/LO outputs hold their old values throughout RUN; there are no intermediate values.
- mult: 2*WIDTH-bit signed product of the latched operands; HI = upper WIDTH bits, LO = lower WIDTH bits.
- multu: same as mult, with an unsigned product.
- div:
  - Signed; quotient truncates toward zero, remainder takes the sign of the dividend. LO=quotient, HI=remainder.
  - Overflow case A=most-negative, B=-1: LO=most-negative, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (div or divu with B=0): runs the full DIV_CYCLES with busy=1, then leaves HI and LO unchanged.
- Arithmetic may be computed combinationally from the latched operands and registered at completion; the cycle count is contractual, the internal algorithm is not.
- The counter must be wide enough for max(MUL_CYCLES, DIV_CYCLES); no wrap-around is permitted.

Test Plan:
- Reset with start=1, op=mult → busy=0 and HI=LO=0 after the edge; no operation starts.
- mult, A=-3 (0xFFFFFFFD), B=7 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu, A=0xFFFFFFFF, B=2 → after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- Signed and unsigned divide cases:
  - div A=-7, B=2 → busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
  - div A=0x80000000, B=-1 → LO=0x80000000, HI=0.
- Divide by zero and issue-while-busy:
  - divu with B=0 after mthi 0x12/mtlo 0x34 → busy 10 cycles; HI=0x12, LO=0x34 unchanged.
  - mtlo 0x55 issued mid-mult → ignored; LO = product only.
- Reset mid-divide:
  - Assert reset at busy cycle 4 of div → busy=0, HI=LO=0 next cycle.
  - A subsequent mult then completes normally in 5 cycles.
